// File: rtl/icache_pkg.sv
// Shared instruction-cache definitions: geometry constants, refill FSM states
// and the word-slot to block bit-range mapping used by the refill engine.
package icache_pkg;

  localparam int dsize  = 32;
  localparam int asize  = 32;
  localparam int bbits  = 5;
  localparam int bsize  = 8 << bbits;
  localparam int nwords = bsize / dsize;
  localparam int wbits  = $clog2(nwords);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } refill_state_e;

  // Word 0 sits in the MSBs of the block so it lines up with the cache's
  // offset decode; returns the top bit of the slot for a -: part-select.
  function automatic int unsigned slot_msb(input logic [wbits-1:0] w);
    return bsize - 1 - int'(w) * dsize;
  endfunction

endpackage

// File: rtl/instr_cache_refill_if.sv
// Bundle of the refill engine's fetch-side, memory-side and cache-fill signals.
// master = refill engine, slave = the fetch/memory/cache environment.
interface instr_cache_refill_if;
  import icache_pkg::*;

  logic               miss_req;
  logic [asize-1:0]   miss_addr;
  logic               busy;
  logic               mem_req;
  logic [asize-1:0]   mem_addr;
  logic               mem_ack;
  logic [dsize-1:0]   mem_data;
  logic               crit_valid;
  logic [dsize-1:0]   crit_data;
  logic [bsize-1:0]   block_out;
  logic [asize-1:0]   fill_addr;
  logic               bwrite;

  modport master (
    input  miss_req, miss_addr, mem_ack, mem_data,
    output busy, mem_req, mem_addr, crit_valid, crit_data,
           block_out, fill_addr, bwrite
  );

  modport slave (
    output miss_req, miss_addr, mem_ack, mem_data,
    input  busy, mem_req, mem_addr, crit_valid, crit_data,
           block_out, fill_addr, bwrite
  );

endinterface

// File: rtl/instr_cache_refill.sv
// Instruction cache refill engine: fetches one block critical-word-first with
// wrap-around, forwards the critical word early, then strobes bwrite once.
module instr_cache_refill
  import icache_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 SYS,
  instr_cache_refill_if.master bus
);

  refill_state_e      state;
  logic [wbits-1:0]   widx;
  logic [wbits-1:0]   widx_nxt;
  logic [wbits-1:0]   count;
  logic               busy;
  logic               mem_req;
  logic [asize-1:0]   mem_addr;
  logic               crit_valid;
  logic [dsize-1:0]   crit_data;
  logic [bsize-1:0]   block_out;
  logic [asize-1:0]   fill_addr;
  logic               bwrite;

  assign widx_nxt = widx + wbits'(1);

  assign bus.busy       = busy;
  assign bus.mem_req    = mem_req;
  assign bus.mem_addr   = mem_addr;
  assign bus.crit_valid = crit_valid;
  assign bus.crit_data  = crit_data;
  assign bus.block_out  = block_out;
  assign bus.fill_addr  = fill_addr;
  assign bus.bwrite     = bwrite;

  // Refill FSM: request, word collection with wrapping slot index, block write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      widx       <= '0;
      count      <= '0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      crit_valid <= 1'b0;
      crit_data  <= '0;
      block_out  <= '0;
      fill_addr  <= '0;
      bwrite     <= 1'b0;
    end else if (SYS) begin
      // Abort: drop the request; any ack this cycle or later is not stored.
      state      <= IDLE;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      crit_valid <= 1'b0;
      bwrite     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          crit_valid <= 1'b0;
          bwrite     <= 1'b0;
          if (bus.miss_req) begin
            fill_addr <= {bus.miss_addr[asize-1:bbits], {bbits{1'b0}}};
            widx      <= bus.miss_addr[bbits-1:2];
            count     <= '0;
            mem_addr  <= bus.miss_addr & ~asize'(3);
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          crit_valid <= 1'b0;
          if (bus.mem_ack) begin
            block_out[slot_msb(widx) -: dsize] <= bus.mem_data;
            if (count == '0) begin
              crit_valid <= 1'b1;
              crit_data  <= bus.mem_data;
            end
            widx     <= widx_nxt;
            count    <= count + wbits'(1);
            // Next word address wraps inside the block, no idle gap.
            mem_addr <= {fill_addr[asize-1:bbits], widx_nxt, 2'b00};
            if (count == wbits'(nwords - 1)) begin
              mem_req <= 1'b0;
              bwrite  <= 1'b1;
              state   <= WRITE;
            end
          end
        end
        WRITE: begin
          bwrite <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
          bwrite  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_cache_refill.sv
// Directed bench for the instruction cache refill engine.
module tb_instr_cache_refill;
  import icache_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  logic SYS;

  instr_cache_refill_if bus ();

  instr_cache_refill dut (
    .CLK   (CLK),
    .RESET (RESET),
    .SYS   (SYS),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Results of the most recent run_refill.
  logic [31:0]  q_addr [$];
  int           crit_cnt;
  logic [31:0]  crit_word;
  int           bw_cnt;
  int           bw_cycle;
  logic [31:0]  bw_fill;
  logic [255:0] bw_block;
  int           stable_bad;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Full block a correct refill of base must produce: slot i holds word at base+4i.
  function automatic logic [255:0] exp_block(input logic [31:0] base);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[255 - 32*i -: 32] = word_at(base + 32'(4*i));
    return b;
  endfunction

  // Issue a miss and act as memory, waiting 'waits' cycles before each ack.
  task automatic run_refill(input logic [31:0] addr, input int waits, input bit toggle);
    int k;
    int wcnt;
    logic [31:0] last;
    q_addr.delete();
    crit_cnt = 0; bw_cnt = 0; bw_cycle = -1; stable_bad = 0; wcnt = 0; last = '0;
    @(negedge CLK);
    bus.miss_req = 1'b1; bus.miss_addr = addr; bus.mem_ack = 1'b0;
    @(posedge CLK); #1;
    k = 1;
    while (k < 80) begin
      if (bus.crit_valid) begin crit_cnt++; crit_word = bus.crit_data; end
      if (bus.bwrite) begin
        bw_cnt++; bw_cycle = k; bw_fill = bus.fill_addr; bw_block = bus.block_out;
      end
      if (!bus.busy) break;
      @(negedge CLK);
      bus.miss_req = (toggle && k < 6) ? k[0] : 1'b0;
      if (bus.mem_req) begin
        if (wcnt > 0 && bus.mem_addr != last) stable_bad++;
        last = bus.mem_addr;
        if (wcnt == waits) begin
          bus.mem_ack = 1'b1; bus.mem_data = word_at(bus.mem_addr);
          q_addr.push_back(bus.mem_addr); wcnt = 0;
        end else begin
          bus.mem_ack = 1'b0; bus.mem_data = 32'hDEAD_BEEF; wcnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
      end
      @(posedge CLK); #1;
      k++;
    end
    bus.mem_ack = 1'b0; bus.miss_req = 1'b0;
    check("refill_done_in_budget", k < 80, 1'b1);
  endtask

  int bw_seen;

  initial begin
    RESET = 1'b1; SYS = 1'b0;
    bus.miss_req = 1'b0; bus.miss_addr = '0; bus.mem_ack = 1'b0; bus.mem_data = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_bwrite", bus.bwrite, 1'b0);
    check("rst_crit_valid", bus.crit_valid, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_fill_addr", bus.fill_addr, 32'h0);
    check("rst_block_out", bus.block_out, 256'h0);
    @(negedge CLK); RESET = 1'b0;

    // Aligned miss, zero wait.
    run_refill(32'h0000_1000, 0, 1'b0);
    check("t1_nacks", q_addr.size(), 8);
    for (int i = 0; i < 8 && i < q_addr.size(); i++)
      check($sformatf("t1_mem_addr%0d", i), q_addr[i], 32'h1000 + 32'(4*i));
    check("t1_crit_cnt", crit_cnt, 1);
    check("t1_crit_data", crit_word, 32'h5A5A_1000);
    check("t1_bw_cnt", bw_cnt, 1);
    check("t1_bw_cycle", bw_cycle, 9);
    check("t1_fill_addr", bw_fill, 32'h1000);
    check("t1_block_msw", bw_block[255:224], 32'h5A5A_1000);
    check("t1_block", bw_block, exp_block(32'h1000));
    check("t1_crit_hold", bus.crit_data, 32'h5A5A_1000);

    // Wrap-around, critical word first.
    run_refill(32'h0000_2014, 0, 1'b0);
    check("t2_nacks", q_addr.size(), 8);
    for (int i = 0; i < 8 && i < q_addr.size(); i++)
      check($sformatf("t2_mem_addr%0d", i), q_addr[i], 32'h2000 + 32'(4*((5 + i) % 8)));
    check("t2_crit_cnt", crit_cnt, 1);
    check("t2_crit_data", crit_word, 32'h5A5A_2014);
    check("t2_slot5", bw_block[95:64], 32'h5A5A_2014);
    check("t2_fill_addr", bw_fill, 32'h2000);
    check("t2_block", bw_block, exp_block(32'h2000));
    check("t2_bw_cycle", bw_cycle, 9);

    // Two wait cycles before every ack.
    run_refill(32'h0000_3008, 2, 1'b0);
    check("t3_nacks", q_addr.size(), 8);
    check("t3_addr_stable", stable_bad, 0);
    check("t3_bw_cycle", bw_cycle, 25);
    check("t3_bw_cnt", bw_cnt, 1);
    check("t3_block", bw_block, exp_block(32'h3000));

    // SYS in IDLE blocks a miss.
    @(negedge CLK); SYS = 1'b1; bus.miss_req = 1'b1; bus.miss_addr = 32'h0000_9000;
    @(posedge CLK); #1;
    check("sys_idle_busy", bus.busy, 1'b0);
    check("sys_idle_mem_req", bus.mem_req, 1'b0);
    @(negedge CLK); SYS = 1'b0; bus.miss_req = 1'b0;

    // Abort after three acks; a coinciding and a later stray ack are ignored.
    bw_seen = 0;
    @(negedge CLK); bus.miss_req = 1'b1; bus.miss_addr = 32'h0000_4000;
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); bus.miss_req = 1'b0;
      bus.mem_ack = 1'b1; bus.mem_data = word_at(bus.mem_addr);
      @(posedge CLK); #1;
      if (bus.bwrite) bw_seen++;
    end
    check("t4_mid_busy", bus.busy, 1'b1);
    @(negedge CLK); SYS = 1'b1; bus.mem_ack = 1'b1;
    @(posedge CLK); #1;
    check("t4_abort_mem_req", bus.mem_req, 1'b0);
    check("t4_abort_busy", bus.busy, 1'b0);
    if (bus.bwrite) bw_seen++;
    @(negedge CLK); SYS = 1'b0; bus.mem_ack = 1'b1; bus.mem_data = 32'hBAD0_BAD0;
    @(posedge CLK); #1;
    check("t4_stray_busy", bus.busy, 1'b0);
    check("t4_stray_mem_req", bus.mem_req, 1'b0);
    if (bus.bwrite) bw_seen++;
    @(negedge CLK); bus.mem_ack = 1'b0;
    @(posedge CLK); #1;
    if (bus.bwrite) bw_seen++;
    check("t4_no_bwrite", bw_seen, 0);
    run_refill(32'h0000_5000, 0, 1'b0);
    check("t4_after_bw_cnt", bw_cnt, 1);
    check("t4_after_fill", bw_fill, 32'h5000);
    check("t4_after_block", bw_block, exp_block(32'h5000));

    // miss_req toggled during FILL is ignored.
    run_refill(32'h0000_6010, 0, 1'b1);
    check("t5_nacks", q_addr.size(), 8);
    for (int i = 0; i < 8 && i < q_addr.size(); i++)
      check($sformatf("t5_mem_addr%0d", i), q_addr[i], 32'h6000 + 32'(4*((4 + i) % 8)));
    check("t5_bw_cnt", bw_cnt, 1);
    @(posedge CLK); #1;
    check("t5_no_second_refill", bus.busy, 1'b0);

    // RESET mid-FILL.
    @(negedge CLK); bus.miss_req = 1'b1; bus.miss_addr = 32'h0000_7000;
    @(posedge CLK); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); bus.miss_req = 1'b0;
      bus.mem_ack = 1'b1; bus.mem_data = word_at(bus.mem_addr);
      @(posedge CLK); #1;
    end
    @(negedge CLK); RESET = 1'b1; SYS = 1'b1;
    @(posedge CLK); #1;
    check("t6_busy", bus.busy, 1'b0);
    check("t6_mem_req", bus.mem_req, 1'b0);
    check("t6_bwrite", bus.bwrite, 1'b0);
    check("t6_crit_valid", bus.crit_valid, 1'b0);
    check("t6_mem_addr", bus.mem_addr, 32'h0);
    check("t6_fill_addr", bus.fill_addr, 32'h0);
    check("t6_crit_data", bus.crit_data, 32'h0);
    check("t6_block_out", bus.block_out, 256'h0);
    @(negedge CLK); RESET = 1'b0; SYS = 1'b0; bus.mem_ack = 1'b0;
    @(posedge CLK); #1;
    check("t6_idle_after", bus.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
